pc_sequencer: RTL and testbench

//   Drives PCWrite/NPCOp of the next-PC unit and the pipeline-register write/flush

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer_sat_counter.sv | 30 +++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: next-PC op codes, FSM states and
// the pipeline control payload.
package pc_sequencer_pkg;

    localparam int unsigned NPC_W   = 3;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    localparam logic [NPC_W-1:0] NPC_PLUS4  = 3'b000;
    localparam logic [NPC_W-1:0] NPC_BRANCH = 3'b001;
    localparam logic [NPC_W-1:0] NPC_JUMP   = 3'b010;
    localparam logic [NPC_W-1:0] NPC_JALR   = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        RUN        = 2'd0,
        LU_STALL   = 2'd1,
        FETCH_WAIT = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic             pc_write;
        logic [NPC_W-1:0] npc_op;
        logic             pipe_hold;
        logic             if_id_write;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             ex_mem_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the PC sequencer (master) and the pipeline/next-PC unit (slave).
interface pc_sequencer_if #(parameter int unsigned CNT_W = 16);
    import pc_sequencer_pkg::*;

    logic               imem_ready;
    logic [NPC_W-1:0]   mem_npcop;
    logic               mem_zero;
    logic               id_ex_memread;
    logic [REG_W-1:0]   id_ex_rd;
    logic [REG_W-1:0]   if_id_rs1;
    logic [REG_W-1:0]   if_id_rs2;
    logic               pc_write;
    logic [NPC_W-1:0]   npc_op;
    logic               pipe_hold;
    logic               if_id_write;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               ex_mem_flush;
    logic [CNT_W-1:0]   redirect_cnt;
    logic [CNT_W-1:0]   stall_cnt;
    logic [STATE_W-1:0] seq_state;

    modport master (
        input  imem_ready, mem_npcop, mem_zero, id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
        output pc_write, npc_op, pipe_hold, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               redirect_cnt, stall_cnt, seq_state
    );

    modport slave (
        output imem_ready, mem_npcop, mem_zero, id_ex_memread, id_ex_rd, if_id_rs1, if_id_rs2,
        input  pc_write, npc_op, pipe_hold, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               redirect_cnt, stall_cnt, seq_state
    );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; reusable for perf counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (inc_i && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pc_sequencer.sv
// Pipeline sequencer: MEM-stage redirects, load-use bubbles and fetch-wait freeze
// for the 5-stage CPU, plus saturating redirect/stall debug counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            rstn,
    pc_sequencer_if.master bus
);

    seq_state_e state_q, state_d;
    pipe_ctrl_t ctrl;
    logic       taken;
    logic       lu_haz;
    logic       redirect_inc;
    logic       stall_inc;

    // Redirect decode; unknown op codes fall through as not taken.
    always_comb begin
        taken = 1'b0;
        case (bus.mem_npcop)
            NPC_BRANCH: taken = bus.mem_zero;
            NPC_JUMP:   taken = 1'b1;
            NPC_JALR:   taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

    assign lu_haz = bus.id_ex_memread && (bus.id_ex_rd != '0) &&
                    ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: reset > fetch-not-ready > redirect > load-use > normal advance.
    always_comb begin
        state_d      = state_q;
        ctrl         = '0;
        ctrl.npc_op  = NPC_PLUS4;
        redirect_inc = 1'b0;
        stall_inc    = 1'b0;
        if (!rstn) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            state_d           = RUN;
        end else if (!bus.imem_ready) begin
            ctrl.pipe_hold = 1'b1;
            state_d        = FETCH_WAIT;
        end else if (taken) begin
            ctrl.pc_write     = 1'b1;
            ctrl.npc_op       = bus.mem_npcop;
            ctrl.if_id_write  = 1'b1;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
            redirect_inc      = 1'b1;
            state_d           = RUN;
        end else if (lu_haz && (state_q != LU_STALL)) begin
            // EX already holds the bubble in LU_STALL, so the hazard is not re-raised.
            ctrl.id_ex_flush = 1'b1;
            stall_inc        = 1'b1;
            state_d          = LU_STALL;
        end else begin
            ctrl.pc_write    = 1'b1;
            ctrl.if_id_write = 1'b1;
            state_d          = RUN;
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (redirect_inc),
        .q_o   (bus.redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (stall_inc),
        .q_o   (bus.stall_cnt)
    );

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.npc_op       = ctrl.npc_op;
    assign bus.pipe_hold    = ctrl.pipe_hold;
    assign bus.if_id_write  = ctrl.if_id_write;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_flush = ctrl.ex_mem_flush;
    assign bus.seq_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int unsigned CNT_W = 4;

    // {pc_write, npc_op, pipe_hold, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [8:0] P_RST   = 9'b0_000_0_0_111;
    localparam logic [8:0] P_HOLD  = 9'b0_000_1_0_000;
    localparam logic [8:0] P_RUN   = 9'b1_000_0_1_000;
    localparam logic [8:0] P_STALL = 9'b0_000_0_0_010;

    typedef struct packed {
        logic [8:0]       ctrl;
        logic [1:0]       st;
        logic [CNT_W-1:0] rc;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic clk;
    logic rstn;

    pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    pc_sequencer #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t       exp_q[$];
    string      name_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [CNT_W-1:0] e_rc = '0;
    logic [CNT_W-1:0] e_sc = '0;
    exp_t       mon_e;
    exp_t       mon_a;
    string      mon_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] tk(input logic [2:0] op);
        return {1'b1, op, 1'b0, 1'b1, 3'b111};
    endfunction

    // One cycle of stimulus; expected counters come from the running model.
    task automatic step(input string nm, input logic rn, input logic rdy,
                        input logic [2:0] op, input logic z, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [8:0] p, input logic [1:0] st,
                        input logic ir, input logic is);
        exp_t e;
        @(posedge clk);
        #1;
        rstn              = rn;
        bus.imem_ready    = rdy;
        bus.mem_npcop     = op;
        bus.mem_zero      = z;
        bus.id_ex_memread = mr;
        bus.id_ex_rd      = rd;
        bus.if_id_rs1     = r1;
        bus.if_id_rs2     = r2;
        e.ctrl = p;
        e.st   = st;
        e.rc   = e_rc;
        e.sc   = e_sc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (!rn) begin
            e_rc = '0;
            e_sc = '0;
        end else begin
            if (ir && (e_rc != {CNT_W{1'b1}})) e_rc = e_rc + CNT_W'(1);
            if (is && (e_sc != {CNT_W{1'b1}})) e_sc = e_sc + CNT_W'(1);
        end
    endtask

    task automatic run(input string nm, input logic [1:0] st);
        step(nm, 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_RUN, st, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = {bus.pc_write, bus.npc_op, bus.pipe_hold, bus.if_id_write,
                     bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
                     bus.seq_state, bus.redirect_cnt, bus.stall_cnt};
            checks++;
            if (mon_a !== mon_e) begin
                failures++;
                $display("FAIL %s: got ctrl=%b st=%0d rc=%0d sc=%0d, required ctrl=%b st=%0d rc=%0d sc=%0d",
                         mon_n, mon_a.ctrl, mon_a.st, mon_a.rc, mon_a.sc,
                         mon_e.ctrl, mon_e.st, mon_e.rc, mon_e.sc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn              = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.mem_npcop     = NPC_PLUS4;
        bus.mem_zero      = 1'b0;
        bus.id_ex_memread = 1'b0;
        bus.id_ex_rd      = 5'd0;
        bus.if_id_rs1     = 5'd0;
        bus.if_id_rs2     = 5'd0;

        // Reset held across three edges; first cycle state is unknown.
        step("reset_a", 1'b0, 1'b1, NPC_PLUS4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_RST, RUN, 1'b0, 1'b0);
        step("reset_b", 1'b0, 1'b1, NPC_PLUS4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_RST, RUN, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run("straight", RUN);

        step("beq_taken", 1'b1, 1'b1, NPC_BRANCH, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, tk(NPC_BRANCH), RUN, 1'b1, 1'b0);
        step("beq_not_taken", 1'b1, 1'b1, NPC_BRANCH, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_RUN, RUN, 1'b0, 1'b0);

        step("lu_rs2", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, P_STALL, RUN, 1'b0, 1'b1);
        step("lu_stall_once", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, P_RUN, LU_STALL, 1'b0, 1'b0);
        run("lu_after", RUN);
        step("lu_rd0", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, P_RUN, RUN, 1'b0, 1'b0);
        step("lu_rs1", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, P_STALL, RUN, 1'b0, 1'b1);
        run("lu_rs1_after", LU_STALL);

        step("fw_jalr_0", 1'b1, 1'b0, NPC_JALR, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_HOLD, RUN, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("fw_jalr_n", 1'b1, 1'b0, NPC_JALR, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_HOLD, FETCH_WAIT, 1'b0, 1'b0);
        step("fw_jalr_ready", 1'b1, 1'b1, NPC_JALR, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, tk(NPC_JALR), FETCH_WAIT, 1'b1, 1'b0);
        run("fw_after", RUN);

        step("simul_taken_lu", 1'b1, 1'b1, NPC_JUMP, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, tk(NPC_JUMP), RUN, 1'b1, 1'b0);
        run("simul_after", RUN);

        step("stall_then_jump_a", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, P_STALL, RUN, 1'b0, 1'b1);
        step("stall_then_jump_b", 1'b1, 1'b1, NPC_JUMP, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, tk(NPC_JUMP), LU_STALL, 1'b1, 1'b0);
        run("stall_then_jump_c", RUN);

        step("stall_then_wait_a", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, P_STALL, RUN, 1'b0, 1'b1);
        step("stall_then_wait_b", 1'b1, 1'b0, NPC_PLUS4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_HOLD, LU_STALL, 1'b0, 1'b0);
        run("stall_then_wait_c", FETCH_WAIT);

        step("unknown_op3", 1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, P_RUN, RUN, 1'b0, 1'b0);
        step("unknown_op7", 1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, P_RUN, RUN, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++)
            step("sat_jump", 1'b1, 1'b1, NPC_JUMP, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, tk(NPC_JUMP), RUN, 1'b1, 1'b0);
        run("sat_hold", RUN);

        step("midrst_stall", 1'b1, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, P_STALL, RUN, 1'b0, 1'b1);
        step("midrst_a", 1'b0, 1'b1, NPC_PLUS4, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, P_RST, LU_STALL, 1'b0, 1'b0);
        step("midrst_b", 1'b0, 1'b1, NPC_PLUS4, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, P_RST, RUN, 1'b0, 1'b0);
        run("midrst_after", RUN);

        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
